reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the write ports of a bank of 8-bit Register instances among several requesters, e.g. the ALU writeback, the memory load path and the immediate loader.
- Each cycle it grants at most one requester, in round-robin order.
- It drives one-hot writeEnable lines plus a shared data bus into the register bank.
- It supports locked bursts, with a bounded lock length so no requester starves.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_REGS, 4, number of target registers (2..16)
DATA_W, 8, register data width
MAX_LOCK, 4, max consecutive locked transfers by one owner (1..15)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester write request
lock  in  NUM_REQ  per-requester: keep ownership after this transfer
addr  in  NUM_REQ*ADDR_W  packed register index per requester, ADDR_W=max(1,clog2(NUM_REGS)), requester i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  combinational one-hot grant; transfer occurs at a rising edge with req[i]&gnt[i]
reg_we  out  NUM_REGS  registered one-hot writeEnable to the register bank
reg_wdata  out  DATA_W  registered data to the register bank In ports
owner  out  clog2(NUM_REQ)  index of last granted requester
locked  out  1  high while in LOCKED state
addr_err  out  1  registered one-cycle pulse: accepted transfer had addr >= NUM_REGS

Behaviour:
- Reset (reset_n low, async): state=ARB, rr_ptr=0, owner=0, lock_cnt=0.
- Reset outputs: reg_we=0, reg_wdata=0, locked=0, addr_err=0. gnt is forced to 0 while reset_n is low.
- States: ARB, LOCKED.
- ARB grant: gnt selects the first asserted req scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. gnt=0 if no req.
- ARB transfer by requester w:
  - rr_ptr <= (w+1) mod NUM_REQ; owner <= w.
  - If lock[w]=1 and MAX_LOCK>1: state <= LOCKED, lock_cnt <= 1.
- LOCKED grant: gnt[owner]=req[owner]; all other gnt bits are 0.
- LOCKED transfer:
  - lock_cnt increments.
  - Return to ARB when lock[owner]=0, or when lock_cnt+1 = MAX_LOCK, with lock_cnt <= 0.
  - rr_ptr stays (owner+1) mod NUM_REQ.
- LOCKED with req[owner]=0: return to ARB next edge with lock_cnt <= 0. No transfer occurs that cycle.
- Write latency:
  - Transfer at edge N sets reg_we[addr]=1 and reg_wdata=wdata[w] during cycle N..N+1.
  - The Register captures at edge N+1.
  - reg_we is a single-cycle pulse per transfer. Back-to-back transfers produce back-to-back pulses.
  - With no transfer, reg_we=0 and reg_wdata holds its last value.
- addr >= NUM_REGS: transfer is still accepted and gnt behaves normally. reg_we stays all 0 and addr_err pulses with the same latency as reg_we.
- Handshake: requester holds req/addr/wdata/lock stable until it samples gnt high at an edge. Dropping req before grant withdraws the request legally.
- gnt depends only on req and state; it has no combinational path from addr, wdata or lock.
- Reset mid-burst: state returns to ARB immediately and any pending reg_we pulse is cleared. No register write occurs for a transfer whose reg_we pulse was cleared.

Test Plan:
- Reset: hold reset_n=0 with req=4'b1111 → gnt=0, reg_we=0, reg_wdata=8'h00. Release, first edge → gnt=4'b0001 transfer, and reg_we pulses the next cycle.
- Round-robin: req=4'b1111 continuously, all lock=0 → grant order 0,1,2,3,0,... with one reg_we pulse per cycle. Req1 addr=2, wdata=8'hA5 → reg_we=4'b0100 and reg_wdata=8'hA5 one cycle after req1's grant.
- Skip idle: req=4'b1010, rr_ptr=0 → gnt=4'b0010, then 4'b1000, then 4'b0010.
- Lock with MAX_LOCK=4: req2 with lock=1 for 6 transfers, req0 also pending → requester 2 wins 4 consecutive transfers (locked=1 during the burst), then gnt=4'b0001.
- Early unlock and req drop: lock owner drops req mid-burst → next cycle state=ARB, locked=0, and another pending requester is granted.
- Bad address: NUM_REGS=3, addr=3, wdata=8'h5A → transfer granted, reg_we=0, addr_err=1 for exactly one cycle. Async reset asserted between a transfer and its reg_we cycle → reg_we stays 0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that shares the write port of a
// register bank among NUM_REQ requesters. It supports bounded locked bursts
// and drives registered one-hot write enables plus a shared data bus.
module reg_write_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int NUM_REGS = 4,
    parameter  int DATA_W   = 8,
    parameter  int MAX_LOCK = 4,
    localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int OWN_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REGS-1:0]       reg_we,
    output logic [DATA_W-1:0]         reg_wdata,
    output logic [OWN_W-1:0]          owner,
    output logic                      locked,
    output logic                      addr_err
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OWN_W-1:0]    r_rr_ptr;
    logic [OWN_W-1:0]    w_rr_ptr_nxt;
    logic [OWN_W-1:0]    r_owner;
    logic [OWN_W-1:0]    w_owner_nxt;
    logic [3:0]          r_lock_cnt;
    logic [3:0]          w_lock_cnt_nxt;

    logic                w_arb_found;
    logic [OWN_W-1:0]    w_arb_idx;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [OWN_W-1:0]    w_win;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_addr_ok;

    logic [NUM_REGS-1:0] r_reg_we;
    logic [DATA_W-1:0]   r_reg_wdata;
    logic                r_addr_err;

    // Index base+k folded back into 0..NUM_REQ-1 (k is always < NUM_REQ).
    function automatic logic [OWN_W-1:0] wrap_idx(input logic [OWN_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return OWN_W'(sum);
    endfunction

    // Round-robin scan: first asserted request starting at r_rr_ptr.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first; a path that leaves it unassigned would infer a latch.
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_arb_found && req[wrap_idx(r_rr_ptr, k)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    // Grant vector: locked owner keeps the port, otherwise the round-robin winner.
    always_comb begin
        w_gnt = '0;
        if (r_state == ST_LOCKED) begin
            w_gnt[r_owner] = req[r_owner];
        end else if (w_arb_found) begin
            w_gnt[w_arb_idx] = 1'b1;
        end
    end

    // The grant is only ever set on a requesting line, so any grant is a transfer.
    assign w_win  = (r_state == ST_LOCKED) ? r_owner : w_arb_idx;
    assign w_xfer = |w_gnt;
    assign gnt    = reset_n ? w_gnt : '0;

    // Winner's address and data, plus range check against the bank size.
    assign w_addr    = addr[w_win*ADDR_W +: ADDR_W];
    assign w_wdata   = wdata[w_win*DATA_W +: DATA_W];
    assign w_addr_ok = ({1'b0, w_addr} < (ADDR_W+1)'(NUM_REGS));

    // FSM next-state: arbitration, burst counting and pointer updates.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_ARB: begin
                if (w_xfer) begin
                    w_rr_ptr_nxt = wrap_idx(w_win, 1);
                    w_owner_nxt  = w_win;
                    if (lock[w_win] && (MAX_LOCK > 1)) begin
                        w_state_nxt    = ST_LOCKED;
                        w_lock_cnt_nxt = 4'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (!req[r_owner]) begin
                    // Owner went idle: release without a transfer.
                    w_state_nxt    = ST_ARB;
                    w_lock_cnt_nxt = 4'd0;
                end else if (!lock[r_owner] || ((r_lock_cnt + 4'd1) == 4'(MAX_LOCK))) begin
                    // Last transfer of the burst: voluntary or forced by the cap.
                    w_state_nxt    = ST_ARB;
                    w_lock_cnt_nxt = 4'd0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt    = ST_ARB;
                w_lock_cnt_nxt = 4'd0;
            end
        endcase
    end

    // FSM state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_lock_cnt <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Register-bank write port: one-cycle enable pulse, data held between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg_we    <= '0;
            r_reg_wdata <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            r_reg_we   <= '0;
            r_addr_err <= 1'b0;
            if (w_xfer) begin
                r_reg_wdata <= w_wdata;
                if (w_addr_ok) begin
                    r_reg_we <= NUM_REGS'(1) << w_addr;
                end else begin
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

    assign reg_we    = r_reg_we;
    assign reg_wdata = r_reg_wdata;
    assign addr_err  = r_addr_err;
    assign owner     = r_owner;
    assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: 4 requesters, 3 registers (so address 3
// is out of range), MAX_LOCK=4. A behavioural model predicts grants and
// pushes the expected write-port result for each cycle into a scoreboard.
module tb_reg_write_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 3;
    localparam int DATA_W   = 8;
    localparam int MAX_LOCK = 4;
    localparam int ADDR_W   = 2;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REGS-1:0]       reg_we;
    logic [DATA_W-1:0]         reg_wdata;
    logic [1:0]                owner;
    logic                      locked;
    logic                      addr_err;

    reg_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W),
        .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .lock     (lock),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .reg_we   (reg_we),
        .reg_wdata(reg_wdata),
        .owner    (owner),
        .locked   (locked),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REGS-1:0] we;
        logic [DATA_W-1:0]   data;
        logic                err;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_locked;
    int          m_rr;
    int          m_owner;
    int          m_cnt;
    logic [7:0]  m_data;

    // Values sampled during the most recent cycle
    logic [3:0]  last_gnt;
    logic        last_locked;
    logic [2:0]  last_we;
    logic [7:0]  last_data;
    logic        last_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_rr     = 0;
        m_owner  = 0;
        m_cnt    = 0;
        m_data   = 8'h00;
        sb.delete();
    endtask

    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        int i;
        g = 4'b0000;
        if (m_locked) begin
            if (req[m_owner]) g[m_owner] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                i = (m_rr + k) % NUM_REQ;
                if (req[i]) begin
                    g[i] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    // Advance the model by one clock edge and queue the expected port result.
    task automatic model_step(input logic [3:0] g);
        exp_t       e;
        int         w;
        logic [1:0] a;
        e.we   = '0;
        e.err  = 1'b0;
        e.data = m_data;
        w      = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g[i] && req[i]) w = i;
        end
        if (w >= 0) begin
            a      = addr[w*ADDR_W +: ADDR_W];
            e.data = wdata[w*DATA_W +: DATA_W];
            m_data = e.data;
            if (int'(a) < NUM_REGS) e.we = 3'b001 << a;
            else                    e.err = 1'b1;
            if (!m_locked) begin
                m_rr    = (w + 1) % NUM_REQ;
                m_owner = w;
                if (lock[w] && MAX_LOCK > 1) begin
                    m_locked = 1'b1;
                    m_cnt    = 1;
                end
            end else if (!lock[w] || (m_cnt + 1 == MAX_LOCK)) begin
                m_locked = 1'b0;
                m_cnt    = 0;
            end else begin
                m_cnt++;
            end
        end else if (m_locked) begin
            m_locked = 1'b0;
            m_cnt    = 0;
        end
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        last_we   = reg_we;
        last_data = reg_wdata;
        last_err  = addr_err;
        if (sb.size() == 0) begin
            check("sb_depth", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("reg_we", reg_we, e.we);
            check("reg_wdata", reg_wdata, e.data);
            check("addr_err", addr_err, e.err);
        end
    endtask

    // One clock cycle; called at a falling edge, returns at the next one.
    task automatic cycle(input logic [3:0] r, input logic [3:0] lk);
        logic [3:0] g;
        req  = r;
        lock = lk;
        #1;
        g = model_gnt();
        check("gnt", gnt, g);
        check("locked", locked, m_locked);
        check("owner", owner, m_owner);
        last_gnt    = gnt;
        last_locked = locked;
        @(posedge clk);
        model_step(g);
        @(negedge clk);
        pop_compare();
    endtask

    // Async reset asserted at a falling edge, released at the next one.
    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        lock    = '0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
        addr[i*ADDR_W +: ADDR_W]  = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_tbl [8];
        logic [3:0] skip_tbl [3];
        logic [3:0] lock_tbl [6];
        logic       lockf_tbl [6];

        rr_tbl    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        skip_tbl  = '{4'b0010, 4'b1000, 4'b0010};
        lock_tbl  = '{4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        lockf_tbl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        reset_n = 1'b0;
        req     = 4'b1111;
        lock    = 4'b0000;
        addr    = '0;
        wdata   = '0;
        model_reset();

        // Reset held with all requests asserted
        @(negedge clk);
        #1;
        check("rst_gnt", gnt, 4'b0000);
        check("rst_reg_we", reg_we, 3'b000);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_locked", locked, 1'b0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_owner", owner, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // First cycle after release: requester 0 wins, write pulses next cycle
        set_req(0, 2'd1, 8'h11);
        set_req(1, 2'd2, 8'hA5);
        set_req(2, 2'd0, 8'h33);
        set_req(3, 2'd1, 8'h44);
        cycle(4'b1111, 4'b0000);
        check("first_gnt", last_gnt, 4'b0001);
        check("first_we", last_we, 3'b010);
        check("first_data", last_data, 8'h11);

        // Round robin with everyone requesting
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 4'b0000);
            check("rr_order", last_gnt, rr_tbl[i]);
            if (i == 0) begin
                check("rr_req1_we", last_we, 3'b100);
                check("rr_req1_data", last_data, 8'hA5);
            end
        end

        // Idle requesters are skipped
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1010, 4'b0000);
            check("skip_gnt", last_gnt, skip_tbl[i]);
        end

        // Locked burst capped at MAX_LOCK transfers
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0101, 4'b0100);
            check("lock_gnt", last_gnt, lock_tbl[i]);
            check("lock_flag", last_locked, lockf_tbl[i]);
        end

        // Lock owner drops req mid-burst
        do_reset();
        cycle(4'b0110, 4'b0010);
        check("drop_gnt0", last_gnt, 4'b0010);
        cycle(4'b0110, 4'b0010);
        check("drop_lock1", last_locked, 1'b1);
        cycle(4'b0100, 4'b0010);
        check("drop_gnt2", last_gnt, 4'b0000);
        check("drop_no_we", last_we, 3'b000);
        cycle(4'b0100, 4'b0000);
        check("drop_gnt3", last_gnt, 4'b0100);
        check("drop_lock3", last_locked, 1'b0);

        // Out-of-range address
        do_reset();
        set_req(0, 2'd3, 8'h5A);
        cycle(4'b0001, 4'b0000);
        check("bad_gnt", last_gnt, 4'b0001);
        check("bad_we", last_we, 3'b000);
        check("bad_err", last_err, 1'b1);
        cycle(4'b0000, 4'b0000);
        check("bad_err_clr", last_err, 1'b0);
        check("bad_data_hold", last_data, 8'h5A);

        // Reset between a transfer and its write cycle
        do_reset();
        set_req(0, 2'd1, 8'h77);
        req  = 4'b0001;
        lock = 4'b0000;
        #1;
        check("mid_gnt", gnt, 4'b0001);
        @(posedge clk);
        #1;
        check("mid_we_pre", reg_we, 3'b010);
        reset_n = 1'b0;
        #1;
        check("mid_we_cleared", reg_we, 3'b000);
        check("mid_gnt_rst", gnt, 4'b0000);
        req = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        cycle(4'b0000, 4'b0000);
        check("mid_we_after", last_we, 3'b000);

        // Random traffic against the model
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                set_req(i, 2'($urandom_range(0, 3)), 8'($urandom));
            end
            cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
